// File: rtl/debounce_scheduler.sv
// Time-shared switch debouncer: one counter and a two-state FSM qualify one channel at a time.
// Define DEBOUNCE_SCHED_SYNC_EN to add a 2-flop synchronizer on every i_Bouncy bit.
module debounce_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int IDX_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_CH-1:0] i_Bouncy,
  output logic [NUM_CH-1:0] o_Debounced,
  output logic              o_Event_Valid,
  output logic [IDX_W-1:0]  o_Event_Index,
  output logic              o_Event_Rise,
  output logic              o_Busy
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W:0]   NUM_CH_W = (IDX_W + 1)'(NUM_CH);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_VERIFY = 1'b1;

  logic [NUM_CH-1:0] w_s_in;
  logic [NUM_CH-1:0] w_mismatch;
  logic [IDX_W-1:0]  w_rot_idx [NUM_CH];
  logic [NUM_CH-1:0] w_rot_hit;
  logic [IDX_W-1:0]  w_pick;
  logic              w_found;
  logic [IDX_W-1:0]  w_next_ptr;

  logic [0:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_cand;
  logic [NUM_CH-1:0] r_debounced;
  logic              r_event_valid;
  logic [IDX_W-1:0]  r_event_index;
  logic              r_event_rise;

`ifdef DEBOUNCE_SCHED_SYNC_EN
  logic [NUM_CH-1:0] r_sync_meta;
  logic [NUM_CH-1:0] r_sync;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_sync
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        r_sync_meta[gi] <= 1'b0;
        r_sync[gi]      <= 1'b0;
      end else begin
        r_sync_meta[gi] <= i_Bouncy[gi];
        r_sync[gi]      <= r_sync_meta[gi];
      end
    end
  end

  assign w_s_in = r_sync;
`else
  assign w_s_in = i_Bouncy;
`endif

  assign w_mismatch = w_s_in ^ r_debounced;

  // Slot gi of the rotated view is channel (r_ptr + gi) mod NUM_CH.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rot
    logic [IDX_W:0] w_sum;
    assign w_sum          = {1'b0, r_ptr} + (IDX_W + 1)'(gi);
    assign w_rot_idx[gi]  = (w_sum >= NUM_CH_W) ? IDX_W'(w_sum - NUM_CH_W) : w_sum[IDX_W-1:0];
    assign w_rot_hit[gi]  = w_mismatch[w_rot_idx[gi]];
  end

  // Walk slots from the top down so the slot nearest the pointer wins.
  always_comb begin
    w_pick  = '0;
    w_found = |w_rot_hit;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_rot_hit[i]) begin
        w_pick = w_rot_idx[i];
      end
    end
  end

  assign w_next_ptr = (r_cand == IDX_LAST) ? '0 : r_cand + IDX_W'(1);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_ptr         <= '0;
      r_cand        <= '0;
      r_debounced   <= '0;
      r_event_valid <= 1'b0;
      r_event_index <= '0;
      r_event_rise  <= 1'b0;
    end else begin
      r_event_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_cand  <= w_pick;
            r_cnt   <= '0;
            r_state <= S_VERIFY;
          end
        end
        S_VERIFY: begin
          if (w_s_in[r_cand] == r_debounced[r_cand]) begin
            // Advancing past an aborted channel keeps a chattering switch from starving others.
            r_ptr   <= w_next_ptr;
            r_state <= S_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_debounced[r_cand] <= ~r_debounced[r_cand];
            r_event_valid       <= 1'b1;
            r_event_index       <= r_cand;
            r_event_rise        <= ~r_debounced[r_cand];
            r_ptr               <= w_next_ptr;
            r_state             <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_Debounced   = r_debounced;
  assign o_Event_Valid = r_event_valid;
  assign o_Event_Index = r_event_index;
  assign o_Event_Rise  = r_event_rise;
  assign o_Busy        = (r_state == S_VERIFY);

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler: events are queued when stimulus is applied and
// matched by a monitor whenever o_Event_Valid pulses.
module tb_debounce_scheduler;

  localparam int NCH = 4;
  localparam int LIM = 4;
`ifdef DEBOUNCE_SCHED_SYNC_EN
  localparam int LAT = LIM + 3;
`else
  localparam int LAT = LIM + 1;
`endif

  logic           clk    = 1'b0;
  logic           rst_n  = 1'b0;
  logic [NCH-1:0] bouncy = '0;
  logic [NCH-1:0] o_deb;
  logic           o_valid;
  logic [1:0]     o_idx;
  logic           o_rise;
  logic           o_busy;

  typedef struct packed {
    logic [1:0]     idx;
    logic           rise;
    logic [NCH-1:0] deb;
  } ev_t;

  ev_t            exp_q[$];
  logic [NCH-1:0] exp_deb = '0;
  int             tests   = 0;
  int             fails   = 0;

  debounce_scheduler #(
    .NUM_CH        (NCH),
    .DEBOUNCE_LIMIT(LIM)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_Bouncy     (bouncy),
    .o_Debounced  (o_deb),
    .o_Event_Valid(o_valid),
    .o_Event_Index(o_idx),
    .o_Event_Rise (o_rise),
    .o_Busy       (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_ev(input logic [1:0] idx, input logic rise, input logic [NCH-1:0] deb);
    ev_t e;
    e.idx  = idx;
    e.rise = rise;
    e.deb  = deb;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every event pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      chk("ev_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        ev_t e;
        e = exp_q.pop_front();
        $display("[TB] event idx=%0d rise=%0d deb=%b (exp idx=%0d rise=%0d deb=%b)",
                 o_idx, o_rise, o_deb, e.idx, e.rise, e.deb);
        chk("ev_index", 32'(o_idx), 32'(e.idx));
        chk("ev_rise",  32'(o_rise), 32'(e.rise));
        chk("ev_deb",   32'(o_deb), 32'(e.deb));
      end
    end
  end

  // One channel changes; checks exact commit latency and the single-cycle pulse.
  task automatic single(input logic [NCH-1:0] val, input logic [1:0] idx, input logic rise,
                        input logic [NCH-1:0] deb_after, input string tag);
    bouncy = val;
    push_ev(idx, rise, deb_after);
    wait_neg(LAT - 1);
    chk({tag, "_deb_pre"}, 32'(o_deb), 32'(exp_deb));
    chk({tag, "_busy_pre"}, 32'(o_busy), 32'd1);
    wait_neg(1);
    chk({tag, "_deb_post"}, 32'(o_deb), 32'(deb_after));
    chk({tag, "_valid"}, 32'(o_valid), 32'd1);
    chk({tag, "_idx"}, 32'(o_idx), 32'(idx));
    chk({tag, "_rise"}, 32'(o_rise), 32'(rise));
    wait_neg(1);
    chk({tag, "_valid_drop"}, 32'(o_valid), 32'd0);
    chk({tag, "_busy_drop"}, 32'(o_busy), 32'd0);
    exp_deb = deb_after;
  endtask

  // Two channels pending together; the pointer decides which commits first.
  task automatic dual(input logic [NCH-1:0] val,
                      input logic [1:0] idx1, input logic rise1, input logic [NCH-1:0] deb1,
                      input logic [1:0] idx2, input logic rise2, input logic [NCH-1:0] deb2,
                      input string tag);
    bouncy = val;
    push_ev(idx1, rise1, deb1);
    push_ev(idx2, rise2, deb2);
    wait_neg(LAT);
    chk({tag, "_first_valid"}, 32'(o_valid), 32'd1);
    chk({tag, "_first_idx"}, 32'(o_idx), 32'(idx1));
    chk({tag, "_first_deb"}, 32'(o_deb), 32'(deb1));
    wait_neg(LIM + 1);
    chk({tag, "_second_valid"}, 32'(o_valid), 32'd1);
    chk({tag, "_second_idx"}, 32'(o_idx), 32'(idx2));
    chk({tag, "_second_rise"}, 32'(o_rise), 32'(rise2));
    chk({tag, "_second_deb"}, 32'(o_deb), 32'(deb2));
    wait_neg(1);
    chk({tag, "_busy_end"}, 32'(o_busy), 32'd0);
    exp_deb = deb2;
  endtask

  // Flip the masked channel for 3 cycles (< LIM) and restore it: no commit allowed.
  task automatic bounce(input logic [NCH-1:0] mask, input string tag);
    logic [NCH-1:0] base;
    base   = bouncy;
    bouncy = base ^ mask;
    wait_neg(3);
    bouncy = base;
    wait_neg(LAT + 3);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_deb"}, 32'(o_deb), 32'(exp_deb));
  endtask

  initial begin
    bit seen;
    wait_neg(2);
    chk("rst_deb",   32'(o_deb),   32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_idx",   32'(o_idx),   32'd0);
    chk("rst_rise",  32'(o_rise),  32'd0);
    chk("rst_busy",  32'(o_busy),  32'd0);
    rst_n = 1'b1;

    single(4'b0100, 2'd2, 1'b1, 4'b0100, "press_ch2");

    // Reset while channel 0 is being verified.
    bouncy = 4'b0101;
    wait_neg(LAT - 2);
    chk("midrst_busy_before", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_deb",   32'(o_deb),   32'd0);
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_idx",   32'(o_idx),   32'd0);
    chk("midrst_rise",  32'(o_rise),  32'd0);
    chk("midrst_busy",  32'(o_busy),  32'd0);
    exp_deb = '0;
    wait_neg(2);
    rst_n = 1'b1;
    dual(4'b0101, 2'd0, 1'b1, 4'b0001, 2'd2, 1'b1, 4'b0101, "post_rst");

    single(4'b0100, 2'd0, 1'b0, 4'b0100, "release_ch0");
    single(4'b0000, 2'd2, 1'b0, 4'b0000, "release_ch2");

    bounce(4'b0010, "bounce_ch1");
    chk("hold_idx",  32'(o_idx),  32'd2);
    chk("hold_rise", 32'(o_rise), 32'd0);
    bounce(4'b1000, "bounce_ch3");

    dual(4'b1001, 2'd0, 1'b1, 4'b0001, 2'd3, 1'b1, 4'b1001, "rr_ptr0");
    bounce(4'b0001, "bounce_ch0");
    dual(4'b0000, 2'd3, 1'b0, 4'b0001, 2'd0, 1'b0, 4'b0000, "rr_ptr1");
    bounce(4'b1000, "bounce_ch3b");

    // Channel 0 chatters every 2 cycles while channel 1 is held high.
    seen   = 1'b0;
    bouncy = 4'b0011;
    push_ev(2'd1, 1'b1, 4'b0010);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i % 2 == 1) bouncy[0] = ~bouncy[0];
      if (o_deb[1]) seen = 1'b1;
    end
    bouncy = 4'b0010;
    wait_neg(LAT + 6);
    chk("starve_ch1_committed", 32'(seen), 32'd1);
    chk("starve_deb",  32'(o_deb),  32'h2);
    chk("starve_idx",  32'(o_idx),  32'd1);
    chk("starve_rise", 32'(o_rise), 32'd1);
    chk("starve_busy", 32'(o_busy), 32'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/debounce_scheduler.md
Name: debounce_scheduler

Overview:
- Time-shared debounce engine for up to NUM_CH bouncy switch inputs; one counter and one FSM replace per-switch filter instances.
- A round-robin scheduler picks a switch whose raw level differs from its debounced level and qualifies it for DEBOUNCE_LIMIT cycles.
- It then commits the new level and emits a one-cycle change event.
- Sits between board switch pins and toggle/LED logic; o_Debounced bits are drop-in replacements for individual filter outputs.

Parameters:
- NUM_CH, 4, number of switch channels (2..8).
- DEBOUNCE_LIMIT, 250000, consecutive stable cycles required to commit a change (>=1).
- IDX_W, $clog2(NUM_CH), width of channel index (minimum 1).

Ports:
- i_Clk  input  1  system clock.
- i_Rst_L  input  1  asynchronous active-low reset.
- i_Bouncy  input  NUM_CH  raw switch levels, bit k = channel k.
- o_Debounced  output  NUM_CH  committed stable levels.
- o_Event_Valid  output  1  one-cycle pulse on each commit.
- o_Event_Index  output  IDX_W  channel of last commit.
- o_Event_Rise  output  1  1 = last commit was 0->1, 0 = 1->0.
- o_Busy  output  1  high while FSM is in VERIFY.

Behaviour:
- Reset (async, i_Rst_L=0): o_Debounced=0, o_Event_Valid=0, o_Event_Index=0, o_Event_Rise=0, o_Busy=0; state IDLE, counter=0, round-robin pointer=0. Reset mid-VERIFY discards the candidate with no event.
- Mismatch vector m = s_In XOR o_Debounced. s_In is i_Bouncy, or the synchronized copy (see Optional Feature).
- State IDLE:
  - If m==0, stay.
  - Otherwise select the first set bit of m searching from pointer upward, wrapping modulo NUM_CH; latch it as candidate k; counter=0; go to VERIFY.
- State VERIFY, evaluated each cycle on channel k only:
  - s_In[k]==o_Debounced[k] (reverted): abort, go to IDLE, pointer=(k+1) mod NUM_CH, no event.
  - Else if counter==DEBOUNCE_LIMIT-1: commit. o_Debounced[k] toggles; o_Event_Valid=1 for exactly one cycle; o_Event_Index=k; o_Event_Rise=new level; pointer=(k+1) mod NUM_CH; go to IDLE.
  - Else counter increments.
- Latency: mismatch sampled in IDLE at edge E0 -> committed and event visible after edge E(DEBOUNCE_LIMIT), i.e. DEBOUNCE_LIMIT+1 clocks.
- Counter width $clog2(DEBOUNCE_LIMIT+1); it never exceeds DEBOUNCE_LIMIT-1.
- Other channels changing during VERIFY are not tracked; they are serviced later from IDLE. Worst-case wait per channel is (NUM_CH-1)*(DEBOUNCE_LIMIT+1) cycles plus abort cycles. Pointer advance after an abort prevents a chattering channel from starving others.
- A channel that bounces back to its old level before being selected produces no event.
- o_Event_Index and o_Event_Rise hold their values between events.
- o_Busy=1 exactly while in VERIFY.
- After reset with a switch held at 1, that channel is debounced normally and produces a rise event.

Optional Feature:
- Macro DEBOUNCE_SCHED_SYNC_EN.
- Defined: each i_Bouncy bit passes through a 2-flop synchronizer (reset to 0) before use as s_In. All latencies grow by 2 clocks.
- Undefined: s_In = i_Bouncy directly, for callers that already synchronize.

Test Plan:
- Reset/defaults: assert i_Rst_L=0 mid-VERIFY with i_Bouncy=4'b0001, DEBOUNCE_LIMIT=4 -> all outputs 0 immediately, no event; after release, channel 0 commits 5 clocks later with o_Event_Valid pulse, Index=0, Rise=1.
- Clean press: LIMIT=4, i_Bouncy[2] 0->1 held -> o_Debounced[2]=1 exactly 5 clocks after first IDLE sample; single Valid pulse, Index=2, Rise=1. Release gives the same timing with Rise=0.
- Bounce rejection: LIMIT=4, i_Bouncy[1] high 3 cycles then low -> no change, no event, FSM back in IDLE, pointer=2.
- Round-robin: channels 0 and 3 rise in the same cycle, pointer=0 -> channel 0 commits first, then channel 3, giving two events 5 and 10+ clocks later. Repeat with pointer=1 -> channel 3 commits first.
- Starvation guard: channel 0 chatters every 2 cycles while channel 1 held high -> channel 1 commits within bounded time, Index=1.
- Sync feature: with DEBOUNCE_SCHED_SYNC_EN defined, the clean press test shows commit at 7 clocks instead of 5.
